serial_pattern_gen: RTL
=======================

Name: serial_pattern_gen

Overview:
Serial test-pattern transmitter for the bit-serial sequence detectors on the D_in/Detect interface.
- Loads a programmable pattern of 1..PAT_W bits.
- Shifts it out MSB-first, one bit per clock.
- Repeats it a programmed number of times, with an optional idle gap between bursts.
- Sits upstream of a detector in bring-up and verification fabrics; d_out connects directly to the detector's D_in.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of len_in; must satisfy 2**LEN_W > PAT_W.
- REP_W, 4, width of the repeat count.
- GAP_W, 4, width of the inter-burst gap count.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- pat_in  input  PAT_W  pattern; bit len-1 is transmitted first.
- len_in  input  LEN_W  pattern length in bits.
- rep_in  input  REP_W  extra repeats; bursts sent = rep_in+1.
- gap_in  input  GAP_W  idle cycles between bursts.
- d_out  output  1  serial data (to detector D_in).
- d_valid  output  1  high while d_out carries a pattern bit.
- busy  output  1  high from the cycle after accepted start until DONE exits.
- done  output  1  one-cycle pulse after the last bit of the last burst.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; d_out=0, d_valid=0, busy=0, done=0; all counters and the pattern register cleared. Reset mid-operation aborts immediately, with no done pulse.
- Reset wins over start in the same cycle.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Outputs d_out=0, d_valid=0, busy=0.
  - On start=1, capture pat_in, len_in, rep_in, gap_in, then go to SHIFT.
  - len_in=0 ignores start (stay IDLE).
  - len_in>PAT_W is clamped to PAT_W.
- SHIFT:
  - d_valid=1; d_out = pat[bit_idx]; bit_idx starts at len-1 and decrements each clock.
  - Latency: start sampled at edge N gives the first bit on d_out during cycle N+1.
  - When bit_idx=0:
    - if bursts remain and gap>0, go to GAP;
    - if bursts remain and gap=0, reload bit_idx=len-1 and stay in SHIFT (back-to-back, no bubble);
    - otherwise go to DONE.
- GAP: d_valid=0, d_out=0 for exactly gap cycles, then SHIFT with bit_idx=len-1.
- DONE: done=1 and busy=1 for one cycle, then IDLE. A new start is accepted in the IDLE cycle that follows.
- start while busy: ignored; captured registers are not disturbed by changes on any *_in port while busy.
- Counters:
  - burst counter is REP_W+1 bits wide, so rep_in all-ones gives 2**REP_W bursts with no wrap;
  - gap counter counts down from gap to 1;
  - all arithmetic is unsigned.

Optional Feature:
Macro PATGEN_ALT_INVERT_EN.
- Defined: odd-numbered bursts (2nd, 4th, ...) are transmitted bit-inverted, so one run exercises both polarities of a detector (e.g. 1110 then 0001). d_valid timing is unchanged.
- Not defined: every burst is identical to the captured pattern; no invert logic is synthesized.

Decomposition:
- Package patgen_pkg:
  - state enum (IDLE, SHIFT, GAP, DONE) as a 2-bit typedef;
  - default parameter constants;
  - a localparam function for clamped length.
- Sub-module pat_piso: parameterized parallel-in serial-out register with load, index reload, and optional invert. The FSM and counters stay in serial_pattern_gen.

Test Plan:
- Single burst: pat_in=8'b0000_1110, len=4, rep=0, gap=0, start at cycle 0 → d_out 1,1,1,0 on cycles 1-4 with d_valid=1; done=1 on cycle 5; busy low on cycle 6.
- Repeat with gap: pat=3'b101, len=3, rep=2, gap=2 → 101,00,101,00,101; d_valid low on the gap cycles only; done on cycle 14.
- Back-to-back: len=2, pat=2'b10, rep=3, gap=0 → 10101010 contiguous over cycles 1-8 with no d_valid bubble; done on cycle 9.
- Boundaries:
  - len=0 with start → no busy, no done;
  - len=15 → behaves as len=8;
  - start pulsed during SHIFT with a new pat_in → output stream unchanged.
- Reset mid-burst: rst asserted on the 3rd bit → the next cycle has all outputs 0, state IDLE, no done; a subsequent start sends the full pattern.
- With PATGEN_ALT_INVERT_EN: pat=4'b1110, rep=1, gap=0 → 11100001; feeding this into the Mealy detector gives two detect pulses.

Source files
------------

// File: rtl/patgen_pkg.sv
// ---------------------------------------------------------------------------
// patgen_pkg
// Shared types and constants for serial_pattern_gen and pat_piso.
//   state_t   : controller state encoding (IDLE, SHIFT, GAP, DONE)
//   DEF_*     : default parameter values
//   clamp_len : limits a requested pattern length to the register width
// ---------------------------------------------------------------------------
package patgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;
    localparam int DEF_GAP_W = 4;

    // Lengths beyond the pattern register are treated as the full register.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pat_piso.sv
// ---------------------------------------------------------------------------
// pat_piso
// Parallel-in serial-out pattern register. Holds the captured pattern and
// its length and presents pat[idx] on d, idx counting down toward zero.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture pat_in/len_in, idx <= len_in-1
//   reload     : idx <= len-1 to start another burst of the same pattern
//   shift      : idx <= idx-1
//   pat_in     : pattern to capture
//   len_in     : pattern length, already clamped to 1..PAT_W
//   d          : current pattern bit
//   last       : idx is zero (current bit is the final bit of the burst)
// Build option PATGEN_ALT_INVERT_EN: every reload toggles an invert flag,
// so alternate bursts are sent bit-inverted.
// ---------------------------------------------------------------------------
module pat_piso
    import patgen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    output logic             d,
    output logic             last
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;

    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            pat_q <= pat_in;
            len_q <= len_in;
            idx_q <= IDX_W'(len_in - LEN_W'(1));
        end else if (reload) begin
            idx_q <= IDX_W'(len_q - LEN_W'(1));
        end else if (shift) begin
            idx_q <= idx_q - IDX_W'(1);
        end
    end

    assign last = (idx_q == '0);

`ifdef PATGEN_ALT_INVERT_EN
    logic inv_q;

    // First burst is true polarity; each following burst flips.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            inv_q <= 1'b0;
        end else if (reload) begin
            inv_q <= ~inv_q;
        end
    end

    assign d = pat_q[idx_q] ^ inv_q;
`else
    assign d = pat_q[idx_q];
`endif

endmodule

// File: rtl/serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// serial_pattern_gen
// Serial test-pattern transmitter: sends a 1..PAT_W bit pattern MSB-first,
// rep_in+1 times, with gap_in idle cycles between bursts.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request, sampled only in IDLE
//   pat_in   : pattern, bit len-1 sent first
//   len_in   : pattern length (0 ignored, >PAT_W clamped to PAT_W)
//   rep_in   : extra repeats (bursts = rep_in+1)
//   gap_in   : idle cycles between bursts
//   d_out    : serial data
//   d_valid  : d_out carries a pattern bit
//   busy     : transfer in progress (through the DONE cycle)
//   done     : one-cycle pulse after the last bit of the last burst
// Build option PATGEN_ALT_INVERT_EN: 2nd, 4th, ... bursts sent inverted.
// ---------------------------------------------------------------------------
module serial_pattern_gen
    import patgen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [REP_W:0]   burst_q;    // bursts still to send, current one included
    logic [GAP_W-1:0] gap_q;      // captured gap length
    logic [GAP_W-1:0] gap_cnt_q;  // counts gap_q down to 1
    logic [LEN_W-1:0] len_c;
    logic             load, reload, shift;
    logic             piso_d, piso_last, more_bursts;

    assign len_c       = LEN_W'(clamp_len(32'(len_in), PAT_W));
    assign more_bursts = (burst_q > (REP_W+1)'(1));

    pat_piso #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .reload (reload),
        .shift  (shift),
        .pat_in (pat_in),
        .len_in (len_c),
        .d      (piso_d),
        .last   (piso_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                burst_q <= {1'b0, rep_in} + (REP_W+1)'(1);
                gap_q   <= gap_in;
            end else if (reload) begin
                burst_q   <= burst_q - (REP_W+1)'(1);
                gap_cnt_q <= gap_q;
            end else if (state_q == GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && len_in != '0) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!piso_last) begin
                    shift = 1'b1;
                end else if (more_bursts) begin
                    // Reload now so the index is ready whether or not a gap follows.
                    reload = 1'b1;
                    if (gap_q != '0) state_d = GAP;
                end else begin
                    state_d = DONE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(1)) state_d = SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign d_valid = (state_q == SHIFT);
    assign d_out   = d_valid & piso_d;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
